// File: rtl/ddr_train_pkg.sv
// ddr_train_pkg: shared training FSM states, delay-line direction codes and tap helpers.
package ddr_train_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_BACKOFF,
        ST_DONE,
        ST_ERROR
    } train_state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Backoff never steps below tap 0, so clamp the step count to the current tap.
    function automatic logic [7:0] min_tap(input logic [7:0] tap, input int limit);
        return (int'(tap) < limit) ? tap : 8'(limit);
    endfunction

endpackage

// File: rtl/ref_clk_train_ctrl_if.sv
// ref_clk_train_ctrl_if: IOD delay-line and eye-monitor signals between controller and IOD.
interface ref_clk_train_ctrl_if;
    logic [7:0] rx_data;
    logic       delay_line_out_of_range;
    logic       eye_monitor_early;
    logic       eye_monitor_late;
    logic       delay_line_load;
    logic       delay_line_move;
    logic       delay_line_direction;
    logic       eye_monitor_clear_flags;

    modport master (
        input  rx_data, delay_line_out_of_range, eye_monitor_early, eye_monitor_late,
        output delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags
    );

    modport slave (
        output rx_data, delay_line_out_of_range, eye_monitor_early, eye_monitor_late,
        input  delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags
    );
endinterface

// File: rtl/train_sample_chk.sv
// train_sample_chk: compares SAMPLE_CYCLES consecutive words against the first word of the window;
// stable drops if any word differs or an eye-monitor flag is seen.
module train_sample_chk #(
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic       fab_clk,
    input  logic       arst_n,
    input  logic       en,
    input  logic [7:0] data,
    input  logic       flag,
    output logic       last,
    output logic       stable,
    output logic [7:0] pattern
);
    logic [3:0] cnt;

    assign last = int'(cnt) + 1 == SAMPLE_CYCLES;

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt     <= '0;
            stable  <= 1'b0;
            pattern <= '0;
        end else if (en) begin
            cnt <= last ? 4'd0 : cnt + 4'd1;
            if (cnt == 0) begin
                pattern <= data;
                stable  <= !flag;
            end else begin
                stable <= stable && !flag && data == pattern;
            end
        end
    end
endmodule

// File: rtl/ref_clk_train_ctrl.sv
// ref_clk_train_ctrl: sweeps the IOD delay line upward until the reference-clock pattern changes,
// then backs off a few taps from that edge.
module ref_clk_train_ctrl
    import ddr_train_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int MAX_TAP       = 127,
    parameter int BACKOFF_TAPS  = 4
) (
    input  logic                        fab_clk,
    input  logic                        arst_n,
    input  logic                        train_start,
    ref_clk_train_ctrl_if.master        iod,
    output logic                        busy,
    output logic                        train_done,
    output logic                        train_err,
    output logic [7:0]                  tap_count,
    output logic [7:0]                  edge_tap
);
    train_state_t state;
    logic [7:0]   cnt;
    logic [7:0]   ref_pat;
    logic         load, move, dir, clear;
    logic         chk_last, stable;
    logic [7:0]   pattern;
    logic         edge_hit, abort;

    assign iod.delay_line_load         = load;
    assign iod.delay_line_move         = move;
    assign iod.delay_line_direction    = dir;
    assign iod.eye_monitor_clear_flags = clear;

    train_sample_chk #(.SAMPLE_CYCLES(SAMPLE_CYCLES)) u_chk (
        .fab_clk (fab_clk),
        .arst_n  (arst_n),
        .en      (state == ST_SAMPLE),
        .data    (iod.rx_data),
        .flag    (iod.eye_monitor_early || iod.eye_monitor_late),
        .last    (chk_last),
        .stable  (stable),
        .pattern (pattern)
    );

    assign edge_hit = tap_count != 0 && (!stable || pattern != ref_pat);
    assign abort    = (tap_count == 0 && !stable) ||
                      (!edge_hit && (tap_count == 8'(MAX_TAP) || iod.delay_line_out_of_range));

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ref_pat    <= '0;
            load       <= 1'b0;
            move       <= 1'b0;
            dir        <= 1'b0;
            clear      <= 1'b0;
            busy       <= 1'b0;
            train_done <= 1'b0;
            train_err  <= 1'b0;
            tap_count  <= '0;
            edge_tap   <= '0;
        end else begin
            load  <= 1'b0;
            move  <= 1'b0;
            clear <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: if (train_start) begin
                    state      <= ST_LOAD;
                    load       <= 1'b1;
                    tap_count  <= '0;
                    train_done <= 1'b0;
                    train_err  <= 1'b0;
                    busy       <= 1'b1;
                end
                ST_LOAD, ST_STEP: begin
                    state <= ST_SETTLE;
                    cnt   <= '0;
                    clear <= SETTLE_CYCLES == 1;
                end
                // clear is registered, so it is raised one cycle ahead to land on the last settle cycle
                ST_SETTLE: begin
                    cnt   <= cnt + 8'd1;
                    clear <= int'(cnt) + 2 == SETTLE_CYCLES;
                    if (int'(cnt) + 1 == SETTLE_CYCLES) state <= ST_SAMPLE;
                end
                ST_SAMPLE: if (chk_last) state <= ST_EVAL;
                ST_EVAL: begin
                    if (tap_count == 0) ref_pat <= pattern;
                    if (edge_hit) begin
                        state    <= ST_BACKOFF;
                        edge_tap <= tap_count;
                        cnt      <= min_tap(tap_count, BACKOFF_TAPS);
                    end else if (abort) begin
                        state     <= ST_ERROR;
                        train_err <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state     <= ST_STEP;
                        move      <= 1'b1;
                        dir       <= DIR_INC;
                        tap_count <= tap_count + 8'd1;
                    end
                end
                // alternate pulse and idle cycles until the clamped step count is used up
                ST_BACKOFF: if (!move) begin
                    if (cnt == 0) begin
                        state      <= ST_DONE;
                        train_done <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        move      <= 1'b1;
                        dir       <= DIR_DEC;
                        tap_count <= tap_count - 8'd1;
                        cnt       <= cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
